// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Brief    : Several independent odd/even clock dividers with glitch-free
//            divisor reprogramming, per-channel park and rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
    parameter int par_channels    = 2,
    parameter int par_cnt_width   = 16,
    parameter int par_div_default = 1000
) (
    input  logic                          i_clk_mhz,
    input  logic                          i_rstn_mhz,
    input  logic [par_channels-1:0]       i_ch_enable,
    input  logic                          i_div_load,
    input  logic [$clog2(par_channels):0] i_div_sel,
    input  logic [par_cnt_width-1:0]      i_div_value,
    output logic                          o_div_err,
    output logic [par_channels-1:0]       o_div_pending,
    output logic [par_channels-1:0]       o_clk_div,
    output logic [par_channels-1:0]       o_rst_div,
    output logic [par_channels-1:0]       o_ce_rise,
    output logic [par_channels-1:0]       o_ce_fall
);

    localparam int                       SEL_W     = $clog2(par_channels) + 1;
    localparam logic [SEL_W-1:0]         c_num_ch  = SEL_W'(par_channels);
    localparam logic [par_cnt_width-1:0] c_div_def = par_cnt_width'(par_div_default);
    localparam logic [par_cnt_width-1:0] c_div_min = par_cnt_width'(2);
    localparam logic [par_cnt_width-1:0] c_one     = par_cnt_width'(1);

    logic w_load_ok;
    logic err_q;
    logic err_d;

    assign w_load_ok = i_div_load && (i_div_sel < c_num_ch) && (i_div_value >= c_div_min);

    always_comb begin
        err_d = i_div_load && !w_load_ok;
    end

    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_mhz) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_div_err = err_q;

    for (genvar g = 0; g < par_channels; g++) begin : g_ch
        logic [par_cnt_width-1:0] div_q, div_d;
        logic [par_cnt_width-1:0] p_q, p_d;
        logic [par_cnt_width-1:0] pval_q, pval_d;
        logic                     pflag_q, pflag_d;
        logic                     clk_q, clk_d;
        logic                     rstd_q, rstd_d;
        logic                     rise_q, rise_d;
        logic                     fall_q, fall_d;
        logic [par_cnt_width-1:0] w_wrap_pt;
        logic [par_cnt_width-1:0] w_fall_pt;
        logic                     w_hit;

        // High for D - floor(D/2) cycles, so odd divisors spend the extra cycle high.
        assign w_wrap_pt = div_q - c_one;
        assign w_fall_pt = div_q - (div_q >> 1) - c_one;
        assign w_hit     = w_load_ok && (i_div_sel == SEL_W'(g));

        always_comb begin
            div_d   = div_q;
            p_d     = p_q;
            pval_d  = pval_q;
            pflag_d = pflag_q;
            clk_d   = clk_q;
            rstd_d  = rstd_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (p_q == w_wrap_pt) begin
                if (i_ch_enable[g]) begin
                    p_d    = '0;
                    clk_d  = 1'b1;
                    rise_d = 1'b1;
                    if (pflag_q) begin
                        div_d   = pval_q;
                        pflag_d = 1'b0;
                    end
                end else begin
                    // Parking holds p at the wrap point so re-enable restarts immediately.
                    clk_d  = 1'b0;
                    rstd_d = 1'b1;
                end
            end else if (p_q == w_fall_pt) begin
                p_d    = p_q + c_one;
                clk_d  = 1'b0;
                fall_d = 1'b1;
                rstd_d = 1'b0;
            end else begin
                p_d = p_q + c_one;
            end
            // A fresh load outranks the clear from a same-cycle wrap.
            if (w_hit) begin
                pval_d  = i_div_value;
                pflag_d = 1'b1;
            end
        end

        always_ff @(posedge i_clk_mhz) begin
            if (!i_rstn_mhz) begin
                div_q   <= c_div_def;
                p_q     <= c_div_def - c_one;
                pval_q  <= c_div_def;
                pflag_q <= 1'b0;
                clk_q   <= 1'b0;
                rstd_q  <= 1'b1;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                div_q   <= div_d;
                p_q     <= p_d;
                pval_q  <= pval_d;
                pflag_q <= pflag_d;
                clk_q   <= clk_d;
                rstd_q  <= rstd_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign o_clk_div[g]     = clk_q;
        assign o_rst_div[g]     = rstd_q;
        assign o_ce_rise[g]     = rise_q;
        assign o_ce_fall[g]     = fall_q;
        assign o_div_pending[g] = pflag_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Brief    : Scoreboard bench for clock_divider_multi against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

    localparam int NCH = 2;
    localparam int W   = 16;
    localparam int DEF = 1000;

    logic           clk = 1'b0;
    logic           rstn;
    logic [NCH-1:0] en;
    logic           load;
    logic [1:0]     sel;
    logic [W-1:0]   val;
    logic           div_err;
    logic [NCH-1:0] div_pending, clk_div, rst_div, ce_rise, ce_fall;

    clock_divider_multi #(
        .par_channels   (NCH),
        .par_cnt_width  (W),
        .par_div_default(DEF)
    ) dut (
        .i_clk_mhz    (clk),
        .i_rstn_mhz   (rstn),
        .i_ch_enable  (en),
        .i_div_load   (load),
        .i_div_sel    (sel),
        .i_div_value  (val),
        .o_div_err    (div_err),
        .o_div_pending(div_pending),
        .o_clk_div    (clk_div),
        .o_rst_div    (rst_div),
        .o_ce_rise    (ce_rise),
        .o_ce_fall    (ce_fall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] rst;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] pend;
        logic           err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: each channel remembers when its current period began and its divisor.
    int m_t;
    int m_start[NCH];
    int m_d[NCH];
    int m_pend[NCH];
    bit m_pf[NCH];
    bit m_parked[NCH];
    bit m_rst[NCH];

    task automatic model_step(input bit r, input logic [NCH-1:0] e_in,
                              input bit ld, input int s, input int v);
        exp_t e;
        bit   ok;
        int   h;
        int   ph;
        e = '0;
        m_t++;
        if (!r) begin
            for (int c = 0; c < NCH; c++) begin
                m_d[c]      = DEF;
                m_pf[c]     = 1'b0;
                m_parked[c] = 1'b1;
                m_rst[c]    = 1'b1;
                e.rst[c]    = 1'b1;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                h = m_d[c] - m_d[c] / 2;
                if (m_parked[c] || (m_t - m_start[c]) == m_d[c]) begin
                    if (e_in[c]) begin
                        m_parked[c] = 1'b0;
                        m_start[c]  = m_t;
                        if (m_pf[c]) begin
                            m_d[c]  = m_pend[c];
                            m_pf[c] = 1'b0;
                        end
                        e.clk[c]  = 1'b1;
                        e.rise[c] = 1'b1;
                    end else begin
                        m_parked[c] = 1'b1;
                        m_rst[c]    = 1'b1;
                    end
                end else begin
                    ph = m_t - m_start[c];
                    e.clk[c] = (ph < h);
                    if (ph == h) begin
                        e.fall[c] = 1'b1;
                        m_rst[c]  = 1'b0;
                    end
                end
                e.rst[c] = m_rst[c];
            end
            ok = ld && (s < NCH) && (v >= 2);
            if (ok) begin
                m_pend[s] = v;
                m_pf[s]   = 1'b1;
            end
            e.err = ld && !ok;
            for (int c = 0; c < NCH; c++) e.pend[c] = m_pf[c];
        end
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input logic [NCH-1:0] e_in,
                       input bit ld, input int s, input int v);
        @(negedge clk);
        rstn = r;
        en   = e_in;
        load = ld;
        sel  = 2'(s);
        val  = W'(v);
        model_step(r, e_in, ld, s, v);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] e_in);
        for (int i = 0; i < n; i++) cyc(1'b1, e_in, 1'b0, 0, 0);
    endtask

    // Monitor: the DUT presents a full output vector after every edge.
    always begin
        exp_t e;
        exp_t a;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {clk_div, rst_div, ce_rise, ce_fall, div_pending, div_err};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0d clk=%b/%b rst=%b/%b rise=%b/%b fall=%b/%b pend=%b/%b err=%b/%b (got/exp)",
                         vectors, a.clk, e.clk, a.rst, e.rst, a.rise, e.rise,
                         a.fall, e.fall, a.pend, e.pend, a.err, e.err);
            end
        end
    end

    initial begin
        logic [NCH-1:0] ren;
        rstn = 1'b0;
        en   = '1;
        load = 1'b0;
        sel  = '0;
        val  = '0;
        m_t  = 0;
        for (int c = 0; c < NCH; c++) begin
            m_start[c] = 0;
            m_d[c]     = DEF;
            m_pend[c]  = DEF;
            m_pf[c]    = 1'b0;
            m_parked[c] = 1'b1;
            m_rst[c]   = 1'b1;
        end

        // Reset release at default divisor
        repeat (4) cyc(1'b0, 2'b11, 1'b0, 0, 0);
        idle(2100, 2'b11);

        // D=3 on ch0, D=2 on ch1
        cyc(1'b1, 2'b11, 1'b1, 0, 3);
        cyc(1'b1, 2'b11, 1'b1, 1, 2);
        idle(1100, 2'b11);

        // Mid-period reload, last write wins
        repeat (2) cyc(1'b0, 2'b11, 1'b0, 0, 0);
        idle(300, 2'b11);
        cyc(1'b1, 2'b11, 1'b1, 0, 10);
        idle(300, 2'b11);
        cyc(1'b1, 2'b11, 1'b1, 0, 20);
        idle(700, 2'b11);

        // Rejected loads
        cyc(1'b1, 2'b11, 1'b1, 0, 1);
        cyc(1'b1, 2'b11, 1'b1, 1, 0);
        cyc(1'b1, 2'b11, 1'b1, 2, 50);
        cyc(1'b1, 2'b11, 1'b1, 3, 50);
        idle(60, 2'b11);

        // Park and restart ch0
        repeat (2) cyc(1'b0, 2'b11, 1'b0, 0, 0);
        idle(100, 2'b11);
        idle(1500, 2'b10);
        idle(1200, 2'b11);

        // Reset during high phase with a pending load
        repeat (2) cyc(1'b0, 2'b11, 1'b0, 0, 0);
        idle(100, 2'b11);
        cyc(1'b1, 2'b11, 1'b1, 1, 7);
        idle(50, 2'b11);
        cyc(1'b0, 2'b11, 1'b0, 0, 0);
        idle(1100, 2'b11);

        // Randomized traffic with short divisors
        ren = 2'b11;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) ren[0] = ~ren[0];
            if ($urandom_range(0, 149) == 0) ren[1] = ~ren[1];
            cyc($urandom_range(0, 999) != 0, ren,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 60))
                                            : int'($urandom_range(0, 12)));
        end
        idle(3, 2'b11);

        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
